// File: rtl/module_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// pkg_UART
// Shared UART types and constants: control register layout, transmitter
// state encoding and default baud divider.
// Configuration macro: UART_TX_PARITY_EN (adds the PARITY state encoding).
// -----------------------------------------------------------------------------
package pkg_UART;

   localparam int UART_BAUD_DIV_DEFAULT = 434;
   localparam int UART_DATA_BITS        = 8;

   // Control register layout shared with the register block.
   typedef struct packed {
      logic [29:0] reserved;
      logic        busy;
      logic        send;
   } uart_ctrl_t;

   // Encodings are pinned so both builds agree on the common states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4,
      ST_DONE   = 3'd5
   } uart_tx_state_e;

endpackage

// File: rtl/module_uart_tx_baud_tick.sv
// -----------------------------------------------------------------------------
// module_baud_tick_uart
// Bit-period counter for the UART transmitter. Counts 0..BAUD_DIV-1 while
// enabled and flags the last cycle of each bit period with a one-cycle tick.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   en   : count enable (FSM outside IDLE/DONE)
//   clr  : synchronous clear at frame start
//   tick : high in the cycle where the count equals BAUD_DIV-1 (while enabled)
// -----------------------------------------------------------------------------
module module_baud_tick_uart #(
   parameter int BAUD_DIV = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

   logic [CNT_W-1:0] count;

   assign tick = en && (count == LAST);

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= tick ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/module_uart_tx.sv
// -----------------------------------------------------------------------------
// module_uart_tx
// UART transmit engine. On a request from the control register's send bit it
// latches data_tx_i[7:0] and emits one frame (start, 8 data bits LSB first,
// optional even parity, stop), then pulses wr_2_o/send_clear_o for one cycle
// so the control register drops send.
// Configuration macro: UART_TX_PARITY_EN (defined: 8E1 frame, else 8N1).
// Ports:
//   clk_i        : system clock
//   rst_i        : synchronous reset, active-high
//   send_i       : transmit request (control register send bit)
//   data_tx_i    : TX data register, payload in bits [7:0]
//   tx_o         : serial line, idles high (registered)
//   busy_o       : frame in progress, through the DONE cycle (registered)
//   wr_2_o       : one-cycle control register write strobe (registered)
//   send_clear_o : one-cycle clear qualifier, paired with wr_2_o (registered)
// -----------------------------------------------------------------------------
module module_uart_tx
   import pkg_UART::*;
#(
   parameter int BAUD_DIV   = UART_BAUD_DIV_DEFAULT,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  send_i,
   input  logic [DATA_WIDTH-1:0] data_tx_i,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  wr_2_o,
   output logic                  send_clear_o
);

   uart_tx_state_e            state;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [2:0]                bit_idx;
   logic                      tick;
   logic                      baud_en;
   logic                      baud_clr;
`ifdef UART_TX_PARITY_EN
   logic                      parity_q;
`endif

   // Only the low byte of the data register is transmitted.
   logic unused_data_hi;
   assign unused_data_hi = ^data_tx_i[DATA_WIDTH-1:UART_DATA_BITS];

   assign baud_en  = (state != ST_IDLE) && (state != ST_DONE);
   assign baud_clr = (state == ST_IDLE) && send_i;

   module_baud_tick_uart #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud_tick (
      .clk  (clk_i),
      .rst  (rst_i),
      .en   (baud_en),
      .clr  (baud_clr),
      .tick (tick)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the shift register is reset as well, so an aborted frame
         // leaves no stale payload behind.
         state        <= ST_IDLE;
         shift_q      <= '0;
         bit_idx      <= '0;
         tx_o         <= 1'b1;
         busy_o       <= 1'b0;
         wr_2_o       <= 1'b0;
         send_clear_o <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         // NOTE: strobes default low every cycle; only the STOP->DONE
         // transition raises them, which makes them single-cycle by design.
         wr_2_o       <= 1'b0;
         send_clear_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (send_i) begin
                  shift_q <= data_tx_i[UART_DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^data_tx_i[UART_DATA_BITS-1:0];
`endif
                  bit_idx <= '0;
                  tx_o    <= 1'b0;
                  busy_o  <= 1'b1;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  tx_o  <= shift_q[0];
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx_o  <= parity_q;
                     state <= ST_PARITY;
`else
                     tx_o  <= 1'b1;
                     state <= ST_STOP;
`endif
                  end else begin
                     // shift_q[1] is the next bit once the current one retires
                     tx_o    <= shift_q[1];
                     shift_q <= shift_q >> 1;
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (tick) begin
                  tx_o  <= 1'b1;
                  state <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (tick) begin
                  wr_2_o       <= 1'b1;
                  send_clear_o <= 1'b1;
                  state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               tx_o   <= 1'b1;
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               tx_o   <= 1'b1;
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_module_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_module_uart_tx
// Self-checking bench for module_uart_tx with BAUD_DIV=4. A small control
// register model drives send_i and honours the clear strobe; the expected
// line level for every cycle is derived from the frame format.
// Honours UART_TX_PARITY_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_module_uart_tx;

   localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FL = NBITS * BD;

   logic        clk;
   logic        rst;
   logic        send_reg;
   logic        sw_set;
   logic [31:0] data_tx;
   logic        tx;
   logic        busy;
   logic        wr2;
   logic        sclr;

   int checks   = 0;
   int failures = 0;

   module_uart_tx #(
      .BAUD_DIV   (BD),
      .DATA_WIDTH (32)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .send_i       (send_reg),
      .data_tx_i    (data_tx),
      .tx_o         (tx),
      .busy_o       (busy),
      .wr_2_o       (wr2),
      .send_clear_o (sclr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control register model: software write has priority over the clear.
   always @(posedge clk) begin
      if (rst)                 send_reg <= 1'b0;
      else if (sw_set)         send_reg <= 1'b1;
      else if (wr2 && sclr)    send_reg <= 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   // Expected line level at a cycle offset from the first start-bit cycle.
   function automatic logic exp_line(input logic [7:0] b, input int cyc);
      int bit_no;
      bit_no = cyc / BD;
      if (bit_no == 0) return 1'b0;
      if (bit_no <= 8) return b[bit_no-1];
`ifdef UART_TX_PARITY_EN
      if (bit_no == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic load_data(input logic [7:0] b);
      logic [31:0] r;
      r = $urandom();
      data_tx = {r[31:8], b};
   endtask

   // Called on a negedge: software sets send with new data.
   task automatic request(input logic [7:0] b);
      load_data(b);
      sw_set = 1'b1;
   endtask

   // One cycle between the request and the first start-bit cycle.
   task automatic gap();
      @(negedge clk);
      sw_set = 1'b0;
      check("gap_tx", tx, 1);
      check("gap_busy", busy, 0);
      check("gap_wr", wr2, 0);
   endtask

   task automatic frame_body(input logic [7:0] b, input int chg_cyc, input logic [7:0] chg_val,
                             input int abort_cyc, input bit resend, input logic [7:0] next_b);
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         if (i == abort_cyc) begin
            rst = 1'b1;
            @(negedge clk);
            check("abort_tx", tx, 1);
            check("abort_busy", busy, 0);
            check("abort_wr", wr2, 0);
            check("abort_clr", sclr, 0);
            rst = 1'b0;
            for (int k = 0; k < 3 * BD; k++) begin
               @(negedge clk);
               check("abort_quiet_wr", wr2, 0);
               check("abort_quiet_busy", busy, 0);
               check("abort_quiet_tx", tx, 1);
            end
            return;
         end
         check($sformatf("line_b%0h_c%0d", b, i), tx, exp_line(b, i));
         check("frame_busy", busy, 1);
         check("frame_wr", wr2, 0);
         if (i == chg_cyc) data_tx[7:0] = chg_val;
      end
      @(negedge clk);
      check("done_wr", wr2, 1);
      check("done_clr", sclr, 1);
      check("done_busy", busy, 1);
      check("done_tx", tx, 1);
      if (resend) request(next_b);
   endtask

   // After a completed frame with no new write: the line must stay quiet.
   task automatic quiet(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check("post_busy", busy, 0);
         check("post_wr", wr2, 0);
         check("post_tx", tx, 1);
      end
   endtask

   task automatic single_frame(input logic [7:0] b, input int chg_cyc, input logic [7:0] chg_val);
      request(b);
      gap();
      frame_body(b, chg_cyc, chg_val, -1, 1'b0, 8'h00);
      quiet(2 * BD);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b1;
      logic [7:0] b2;
      rst     = 1'b1;
      sw_set  = 1'b0;
      data_tx = '0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_wr", wr2, 0);
      check("rst_clr", sclr, 0);
      rst = 1'b0;

      // Idle after reset.
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         check("idle_tx", tx, 1);
         check("idle_busy", busy, 0);
         check("idle_wr", wr2, 0);
      end

      // Alternating pattern, then 0xA5 (parity bit 0 when enabled).
      single_frame(8'h55, -1, 8'h00);
      single_frame(8'hA5, -1, 8'h00);

      // Data register rewritten during bit 3: payload already latched.
      single_frame(8'h0F, 4 * BD + 1, 8'hF0);

      // Back-to-back: software re-sets send in the DONE cycle.
      b1 = 8'($urandom());
      b2 = 8'($urandom());
      request(b1);
      gap();
      frame_body(b1, -1, 8'h00, -1, 1'b1, b2);
      gap();
      frame_body(b2, -1, 8'h00, -1, 1'b0, 8'h00);
      quiet(2 * BD);

      // Reset during data bit 5, then a clean frame.
      request(8'h3C);
      gap();
      frame_body(8'h3C, -1, 8'h00, 6 * BD + 2, 1'b0, 8'h00);
      single_frame(8'hC3, -1, 8'h00);

      // Randomized payloads with random mid-frame data register writes.
      for (int n = 0; n < 8; n++) begin
         b1 = 8'($urandom());
         b2 = 8'($urandom());
         single_frame(b1, int'($urandom_range(0, FL - 1)), b2);
      end

      // Boundary bytes.
      single_frame(8'h00, -1, 8'h00);
      single_frame(8'hFF, -1, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/module_uart_tx.md
# module_uart_tx

UART transmit engine: serializes one byte per request as an 8N1 frame (optional parity) on the TX line. Sits beside the UART control register: consumes its `send` bit as the request and, on frame completion, issues the write strobe plus clear that drop `send` back to 0. The data byte comes from the UART TX data register.

## Interface
- `BAUD_DIV`, default 434: clock cycles per bit period; legal range 2 and up.
- `DATA_WIDTH`, default 32: width of the data-register bus; only bits [7:0] are transmitted.
- `clk_i` input 1: system clock, all logic on rising edge.
- `rst_i` input 1: synchronous reset, active-high.
- `send_i` input 1: transmit request; the `send` bit of the control register.
- `data_tx_i` input DATA_WIDTH: TX data register; bits [7:0] are the payload.
- `tx_o` output 1: serial line, idles high.
- `busy_o` output 1: high from frame start until the DONE cycle, inclusive.
- `wr_2_o` output 1: one-cycle write strobe to the control register.
- `send_clear_o` output 1: one-cycle clear qualifier, asserted together with `wr_2_o`.

## Operation
- FSM states are IDLE, START, DATA, PARITY, STOP and DONE. PARITY exists only with the macro.
- IDLE:
  - When `send_i`=1, latch `data_tx_i[7:0]` into the shift register, clear the bit counter and baud counter, and go to START.
- START:
  - `tx_o`=0 for BAUD_DIV cycles, then go to DATA.
- DATA:
  - Send 8 bits, LSB first, each for BAUD_DIV cycles.
  - Use a 3-bit index; after bit 7, go to PARITY (macro defined) or STOP (macro undefined).
- PARITY:
  - `tx_o` = XOR of the latched byte (even parity) for BAUD_DIV cycles, then go to STOP.
- STOP:
  - `tx_o`=1 for BAUD_DIV cycles, then go to DONE.
- DONE:
  - Lasts exactly 1 cycle, with `tx_o`=1 and `wr_2_o`=`send_clear_o`=1.
  - Then return to IDLE unconditionally.
- Baud counter:
  - Width $clog2(BAUD_DIV); counts 0..BAUD_DIV-1.
  - A bit boundary is the cycle where the count is BAUD_DIV-1; the count then wraps to 0.
- Changes on `send_i` and `data_tx_i` while in any non-IDLE state are ignored. The payload is latched once.
- Simultaneous software write setting `send` in the DONE cycle: the control register gives its own write priority, so `send` stays 1. The next IDLE cycle then starts a new frame with the new data; this is required behaviour.
- Reset (any state, including mid-frame):
  - Next cycle: state=IDLE, `tx_o`=1, `busy_o`=0, `wr_2_o`=0, `send_clear_o`=0, counters and shift register = 0.
  - No clear pulse is issued for the aborted frame.

## Timing
- `tx_o`, `busy_o`, `wr_2_o` and `send_clear_o` are registered outputs; none is combinational from inputs.
- Latency: edge E samples `send_i`=1 in IDLE. `tx_o` falls and `busy_o` rises in the cycle after E.
- Frame length on `tx_o`:
  - 10·BAUD_DIV cycles without the macro; 11·BAUD_DIV with it.
  - This is followed by 1 DONE cycle.
- Request-to-clear: 10·BAUD_DIV+1 cycles (11·BAUD_DIV+1 with parity) from the cycle after E to the `wr_2_o` pulse.
- After DONE, the control register has `send`=0 on the next cycle. IDLE therefore never re-triggers on a stale request.
- Back-to-back frames: minimum gap between a stop bit and the next start bit is 2 cycles (DONE + IDLE).

## Configuration
- Macro `UART_TX_PARITY_EN`:
  - Defined: PARITY state is compiled in, and one even-parity bit is inserted between D7 and stop (8E1).
  - Undefined: the PARITY state and the parity XOR are absent, and the frame is 8N1.

## Structure
- `pkg_UART` gains:
  - `uart_tx_state_e` (enum, 3 bits).
  - `UART_BAUD_DIV_DEFAULT` = 434.
  - `UART_DATA_BITS` = 8.
- Existing control-register typedef is reused, unchanged.
- One sub-module, `module_baud_tick_uart`: holds the counter and issues a one-cycle `tick` at count BAUD_DIV-1. It is enabled only while the FSM is outside IDLE/DONE and is cleared on start.

## Test plan
All scenarios use BAUD_DIV=4.
- 0x55 with `send_i` pulsed:
  - `tx_o` reads 0,1,0,1,0,1,0,1,0,1 at 4 cycles per bit.
  - `wr_2_o`/`send_clear_o` pulse exactly once, 41 cycles after the frame starts.
- 0xA5 with the macro defined:
  - Data bits are 1,0,1,0,0,1,0,1, then parity 0, then stop 1; 45 cycles total.
- `send_i` held high across two frames, with the clear applied by a control-register model:
  - Exactly one frame is sent.
  - If the model re-sets `send` in the DONE cycle, a second frame starts 2 cycles after the stop bit ends.
- `data_tx_i` changed from 0x0F to 0xF0 during bit 3:
  - Transmitted bits still encode 0x0F.
- `rst_i` asserted during bit 5:
  - Next cycle `tx_o`=1, `busy_o`=0, no `wr_2_o` pulse.
  - A subsequent request sends a full clean frame.
- Idle after reset for 100 cycles:
  - `tx_o`=1, `busy_o`=0, `wr_2_o`=0 throughout.
